// File: rtl/ntt_scale_ninv_pkg.sv
// Shared NTT constants and the pipeline stage record used by the INTT output path.
package ntt_pkg;
   localparam int COEF_WIDTH = 128;
   localparam int Q          = 12289;
   localparam int LOGN_MAX   = 16;
   localparam int LOGN_W     = $clog2(LOGN_MAX + 1);

   typedef struct packed {
      logic                  valid;
      logic [LOGN_W-1:0]     logn;
      logic [COEF_WIDTH-1:0] data;
   } stage_t;
endpackage

// File: rtl/ntt_scale_ninv_if.sv
// Valid/ready stream carrying coefficients into the N^-1 scaler and results out of it.
interface ntt_scale_ninv_if
   import ntt_pkg::*;
#(
   parameter int DW = COEF_WIDTH,
   parameter int LW = LOGN_W
);
   logic [DW-1:0] in_A;
   logic [LW-1:0] in_logn;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] result_int;
   logic          out_valid;
   logic          out_ready;

   modport master (
      output in_A, in_logn, in_valid, out_ready,
      input  in_ready, result_int, out_valid
   );

   modport slave (
      input  in_A, in_logn, in_valid, out_ready,
      output in_ready, result_int, out_valid
   );
endinterface

// File: rtl/ntt_scale_ninv_mod_half_stage.sv
// One registered modular-halving stage: divides by 2 mod Q when this stage index is below logn.
module mod_half_stage
   import ntt_pkg::*;
#(
   parameter int DW = COEF_WIDTH,
   parameter int QV = Q,
   parameter int LW = LOGN_W,
   parameter int K  = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          d_valid,
   input  logic [LW-1:0] d_logn,
   input  logic [DW-1:0] d_data,
   output logic          q_valid,
   output logic [LW-1:0] q_logn,
   output logic [DW-1:0] q_data
);
   localparam logic [LW-1:0] KV = LW'(K);
   localparam logic [DW-1:0] QH = DW'((QV + 1) / 2);

   logic          act;
   logic [DW-1:0] nxt;

   // (x+Q)>>1 for odd x equals (x>>1) + (Q+1)/2, so the DW+1-bit carry never has to be materialised.
   always_comb begin
      act = d_logn > KV;
      nxt = d_data;
      if (act) nxt = {1'b0, d_data[DW-1:1]} + (d_data[0] ? QH : '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_valid <= 1'b0;
         q_logn  <= '0;
         q_data  <= '0;
      end else if (en) begin
         q_valid <= d_valid;
         q_logn  <= d_logn;
         q_data  <= nxt;
      end
   end
endmodule

// File: rtl/ntt_scale_ninv.sv
// Pipelined x * (2^logn)^-1 mod Q with fixed latency and valid/ready backpressure.
// Optional sticky out-of-contract input flag under NTT_SCALE_RANGE_CHK_EN.
module ntt_scale_ninv
   import ntt_pkg::*;
#(
   parameter int pDATA_WIDTH = COEF_WIDTH,
   parameter int pQ          = Q,
   parameter int pLOGN_MAX   = LOGN_MAX,
   parameter int pLATENCY    = 18
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ntt_scale_ninv_if.slave      bus
`ifdef NTT_SCALE_RANGE_CHK_EN
   ,
   output logic                 err_range
`endif
);
   localparam int LW = $clog2(pLOGN_MAX + 1);
   localparam int DW = pDATA_WIDTH;
   localparam int NT = pLATENCY - 1 - pLOGN_MAX;

   if (pQ % 2 == 0) begin : g_bad_q
      $error("ntt_scale_ninv: pQ must be odd");
   end
   if (NT < 0) begin : g_bad_lat
      $error("ntt_scale_ninv: pLATENCY must be >= pLOGN_MAX+1");
   end

   logic          en;
   logic          s0_valid;
   logic [LW-1:0] s0_logn;
   logic [DW-1:0] s0_data;

   // ch[0] is the input register, ch[k+1] is the output of halving stage k.
   logic          ch_valid [pLOGN_MAX+1];
   logic [LW-1:0] ch_logn  [pLOGN_MAX+1];
   logic [DW-1:0] ch_data  [pLOGN_MAX+1];
   logic          unused_logn;

   assign en           = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_valid <= 1'b0;
         s0_logn  <= '0;
         s0_data  <= '0;
      end else if (en) begin
         s0_valid <= bus.in_valid;
         s0_logn  <= bus.in_logn;
         s0_data  <= bus.in_A;
      end
   end

   assign ch_valid[0]  = s0_valid;
   assign ch_logn[0]   = s0_logn;
   assign ch_data[0]   = s0_data;
   assign unused_logn  = ^ch_logn[pLOGN_MAX];

   for (genvar k = 0; k < pLOGN_MAX; k++) begin : g_half
      mod_half_stage #(.DW(DW), .QV(pQ), .LW(LW), .K(k)) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .en      (en),
         .d_valid (ch_valid[k]),
         .d_logn  (ch_logn[k]),
         .d_data  (ch_data[k]),
         .q_valid (ch_valid[k+1]),
         .q_logn  (ch_logn[k+1]),
         .q_data  (ch_data[k+1])
      );
   end

   if (NT == 0) begin : g_no_tail
      assign bus.out_valid  = ch_valid[pLOGN_MAX];
      assign bus.result_int = ch_data[pLOGN_MAX];
   end else begin : g_tail
      logic          t_valid [NT];
      logic [DW-1:0] t_data  [NT];

      // Plain delay so total latency is independent of logn.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < NT; i++) begin
               t_valid[i] <= 1'b0;
               t_data[i]  <= '0;
            end
         end else if (en) begin
            t_valid[0] <= ch_valid[pLOGN_MAX];
            t_data[0]  <= ch_data[pLOGN_MAX];
            for (int i = 1; i < NT; i++) begin
               t_valid[i] <= t_valid[i-1];
               t_data[i]  <= t_data[i-1];
            end
         end
      end

      assign bus.out_valid  = t_valid[NT-1];
      assign bus.result_int = t_data[NT-1];
   end

`ifdef NTT_SCALE_RANGE_CHK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_range <= 1'b0;
      end else if (bus.in_valid && en &&
                   (bus.in_A >= DW'(pQ) || bus.in_logn > LW'(pLOGN_MAX))) begin
         err_range <= 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_ntt_scale_ninv.sv
// Directed bench for ntt_scale_ninv: hand-computed scalings, streaming, stall, reset and range flag.
module tb_ntt_scale_ninv;
   import ntt_pkg::*;

   localparam int DW  = 128;
   localparam int LW  = 5;
   localparam int LAT = 18;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   ntt_scale_ninv_if #(.DW(DW), .LW(LW)) bus ();

`ifdef NTT_SCALE_RANGE_CHK_EN
   logic err_range;
`endif

   ntt_scale_ninv #(.pDATA_WIDTH(DW), .pQ(12289), .pLOGN_MAX(16), .pLATENCY(LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef NTT_SCALE_RANGE_CHK_EN
      ,
      .err_range (err_range)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: multiply by 2^-1 = 6145 (mod 12289) once per effective halving.
   function automatic logic [DW-1:0] ref_scale(input logic [DW-1:0] a, input int n);
      longint r;
      int     m;
      r = longint'(a[31:0]) % 12289;
      m = (n > 16) ? 16 : n;
      for (int i = 0; i < m; i++) r = (r * 6145) % 12289;
      return DW'(r);
   endfunction

   typedef struct {
      logic [DW-1:0] exp;
      int            t;
   } sb_t;

   sb_t sb[$];
   int  en_cnt = 0;
   bit  mon_en = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            assert (sb.size() > 0) else begin
               failures++;
               $error("FAIL sb_extra_output observed=%0d expected=none", bus.result_int);
            end
            if (sb.size() > 0) begin
               sb_t e;
               e = sb.pop_front();
               chk("stream_data", bus.result_int, e.exp);
               chk("stream_latency", DW'(en_cnt - e.t), DW'(LAT));
            end
         end
         if (bus.in_valid && bus.in_ready)
            sb.push_back('{ref_scale(bus.in_A, int'(bus.in_logn)), en_cnt});
         if (!bus.out_valid || bus.out_ready) en_cnt++;
      end
   end

   task automatic send_one(input string tag, input logic [DW-1:0] a, input int n,
                           input logic [DW-1:0] exp);
      int lat;
      bus.in_A     = a;
      bus.in_logn  = LW'(n);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, DW'(lat), DW'(LAT));
      chk(tag, bus.result_int, exp);
      @(posedge clk); #1;
   endtask

   task automatic drain(input string tag);
      int guard;
      bus.in_valid = 1'b0;
      guard = 0;
      while (sb.size() > 0 && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      chk(tag, DW'(sb.size()), DW'(0));
      mon_en = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] held;
      bit            seen;

      bus.in_A      = '0;
      bus.in_logn   = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;

      #1;
      chk("rst_out_valid", DW'(bus.out_valid), DW'(0));
      chk("rst_result", bus.result_int, DW'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_in_ready", DW'(bus.in_ready), DW'(1));

      // Hand-derived: 2^-1=6145, 2^-10=-12=12277, 2^-16=2304, -2^-16=9985.
      send_one("a1_n1", DW'(1), 1, DW'(6145));
      send_one("a1_n10", DW'(1), 10, DW'(12277));
      send_one("a4_n2", DW'(4), 2, DW'(1));
      send_one("qm1_n16", DW'(12288), 16, DW'(9985));
      send_one("zero_n7", DW'(0), 7, DW'(0));
      send_one("qm1_n0", DW'(12288), 0, DW'(12288));
      send_one("qm1_n1", DW'(12288), 1, DW'(6144));
      send_one("a1_n20_sat", DW'(1), 20, DW'(2304));

      // logn=0 stream, back-to-back.
      mon_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         bus.in_A     = DW'(i);
         bus.in_logn  = '0;
         bus.in_valid = 1'b1;
         @(posedge clk); #1;
      end
      drain("stream0_drain");

      // Mixed stream with a 5-cycle downstream stall while input is offered.
      mon_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.in_A     = DW'((i * 613 + 7) % 12289);
         bus.in_logn  = LW'(i % 19);
         bus.in_valid = 1'b1;
         if (i == 19) begin
            bus.out_ready = 1'b0;
            held = bus.result_int;
            repeat (5) begin
               @(negedge clk);
               chk("stall_in_ready", DW'(bus.in_ready), DW'(0));
               chk("stall_out_valid", DW'(bus.out_valid), DW'(1));
               chk("stall_result_hold", bus.result_int, held);
               @(posedge clk);
            end
            #1 bus.out_ready = 1'b1;
         end
         @(posedge clk); #1;
      end
      drain("stall_drain");

      // Reset with the pipeline full and results already emerging.
      for (int i = 0; i < 20; i++) begin
         bus.in_A     = DW'(i + 100);
         bus.in_logn  = LW'(3);
         bus.in_valid = 1'b1;
         @(posedge clk); #1;
      end
      chk("pre_rst_out_valid", DW'(bus.out_valid), DW'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", DW'(bus.out_valid), DW'(0));
      chk("async_rst_result", bus.result_int, DW'(0));
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("held_rst_out_valid", DW'(bus.out_valid), DW'(0));
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      send_one("post_rst_a5_n2", DW'(5), 2, DW'(9218));
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         seen = seen | bus.out_valid;
      end
      chk("no_stale_out", DW'(seen), DW'(0));

      // Out-of-range input; logn=0 keeps the data path a pass-through.
`ifdef NTT_SCALE_RANGE_CHK_EN
      chk("err_range_clear", DW'(err_range), DW'(0));
`endif
      bus.in_A     = DW'(12289);
      bus.in_logn  = '0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
`ifdef NTT_SCALE_RANGE_CHK_EN
      chk("err_range_set", DW'(err_range), DW'(1));
`endif
      repeat (LAT - 1) @(posedge clk);
      #1;
      chk("oor_passthru_valid", DW'(bus.out_valid), DW'(1));
      chk("oor_passthru_data", bus.result_int, DW'(12289));
      repeat (5) @(posedge clk);
      #1;
`ifdef NTT_SCALE_RANGE_CHK_EN
      chk("err_range_sticky", DW'(err_range), DW'(1));
`endif
      rst_n = 1'b0;
      #1;
`ifdef NTT_SCALE_RANGE_CHK_EN
      chk("err_range_rst", DW'(err_range), DW'(0));
`endif
      chk("final_rst_out_valid", DW'(bus.out_valid), DW'(0));
      #4 rst_n = 1'b1;
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
